// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Architectural integer register file with an integrated scoreboard.
// Write-back writes the array and releases the destination's busy bit. Decode
// reads two sources through registered read ports, and issuing uops mark
// their destination busy. A combinational stall holds decode off while a
// source, or the issuing destination, still waits on an in-flight producer.
// x0 reads as zero, ignores writes and is never busy.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   wb_en        write-back enable
//   wb_addr      write-back destination index
//   wb_data      write-back result
//   rd_req       decode read request
//   rs1_addr     source 1 index
//   rs2_addr     source 2 index
//   rs1_data     registered read data, port 1
//   rs2_data     registered read data, port 2
//   rd_valid     read data valid, one cycle after an accepted rd_req
//   issue_valid  decode issues a uop that writes issue_rd
//   issue_rd     destination of the issuing uop
//   stall        combinational hazard indication to decode
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      rd_req,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      rd_valid,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      stall
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     ZERO_DATA = {DATA_WIDTH{1'b0}};

    // Architectural state
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_r;

    // Combinational control
    logic                  wb_write_s;
    logic                  stall_s;
    logic                  rd_accept_s;
    logic                  issue_accept_s;
    logic [NUM_REGS-1:0]   busy_next_s;
    logic [DATA_WIDTH-1:0] rs1_next_s;
    logic [DATA_WIDTH-1:0] rs2_next_s;

    // A register is still pending when it is busy and is not being written
    // back in this cycle; a write-back in progress is forwarded, not waited on.
    function automatic logic hit_f(
        input logic [NUM_REGS-1:0]       busy,
        input logic                      wr,
        input logic [REG_ADDR_WIDTH-1:0] wa,
        input logic [REG_ADDR_WIDTH-1:0] r
    );
        logic result;
        if (r == ZERO_ADDR) begin
            result = 1'b0;
        end else if (wr && (wa == r)) begin
            result = 1'b0;
        end else begin
            result = busy[r];
        end
        return result;
    endfunction

    // Read value for one port: x0 is zero. A same-cycle write-back to the
    // same index takes priority over the stored value.
    function automatic logic [DATA_WIDTH-1:0] read_f(
        input logic [DATA_WIDTH-1:0]     stored,
        input logic                      wr,
        input logic [REG_ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0]     wd,
        input logic [REG_ADDR_WIDTH-1:0] r
    );
        logic [DATA_WIDTH-1:0] result;
        if (r == ZERO_ADDR) begin
            result = ZERO_DATA;
        end else if (wr && (wa == r)) begin
            result = wd;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Effective write-back: writes to x0 do nothing.
    always_comb begin
        wb_write_s = 1'b0;
        if (wb_en && (wb_addr != ZERO_ADDR)) begin
            wb_write_s = 1'b1;
        end else begin
            wb_write_s = 1'b0;
        end
    end

    // Hazard detection, read acceptance and issue acceptance.
    always_comb begin
        stall_s        = 1'b0;
        rd_accept_s    = 1'b0;
        issue_accept_s = 1'b0;
        if ((rd_req || issue_valid) &&
            (hit_f(busy_r, wb_write_s, wb_addr, rs1_addr) ||
             hit_f(busy_r, wb_write_s, wb_addr, rs2_addr) ||
             (issue_valid && hit_f(busy_r, wb_write_s, wb_addr, issue_rd)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        if (rd_req && !stall_s) begin
            rd_accept_s = 1'b1;
        end else begin
            rd_accept_s = 1'b0;
        end
        if (issue_valid && !stall_s && (issue_rd != ZERO_ADDR)) begin
            issue_accept_s = 1'b1;
        end else begin
            issue_accept_s = 1'b0;
        end
    end

    assign stall = stall_s;

    // Next busy vector. The release is applied before the set so that a
    // new producer issuing in the same cycle as the old one retires keeps
    // the register busy.
    always_comb begin
        busy_next_s = busy_r;
        if (wb_write_s) begin
            busy_next_s[wb_addr] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (issue_accept_s) begin
            busy_next_s[issue_rd] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Read data candidates including the write-back forward.
    always_comb begin
        rs1_next_s = read_f(regs_r[rs1_addr], wb_write_s, wb_addr, wb_data, rs1_addr);
        rs2_next_s = read_f(regs_r[rs2_addr], wb_write_s, wb_addr, wb_data, rs2_addr);
    end

    // Register array: cleared on reset, written by write-back (never x0).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wb_write_s) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Scoreboard busy bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Registered read ports. The data outputs hold when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_data <= ZERO_DATA;
            rs2_data <= ZERO_DATA;
            rd_valid <= 1'b0;
        end else if (rd_accept_s) begin
            rs1_data <= rs1_next_s;
            rs2_data <= rs2_next_s;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Drives directed and random traffic into reg_file_sb. A reference model keeps
// the architectural registers and a pending-producer set as plain arrays. The
// driver predicts stall and pushes the expected read results into a queue. A
// separate negedge monitor pops that queue whenever rd_valid is presented and
// checks that the data outputs hold while no read is returned.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          reset;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rd_req;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          rd_valid;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          stall;

    reg_file_sb #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_req      (rd_req),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_valid    (rd_valid),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
    } pair_t;

    // Reference model state
    logic [DW-1:0] reg_m [NR];
    bit            busy_m [NR];
    pair_t         exp_q [$];
    logic [DW-1:0] hold1;
    logic [DW-1:0] hold2;
    bit            mon_en;

    int n_checks;
    int n_err;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus together with the model prediction and update.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic rq,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic iv, input logic [AW-1:0] ird);
        logic          exp_stall;
        bit            pend [NR];
        logic [DW-1:0] nxt [NR];
        pair_t         p;
        @(negedge clk);
        reset       = r;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        rd_req      = rq;
        rs1_addr    = a1;
        rs2_addr    = a2;
        issue_valid = iv;
        issue_rd    = ird;
        #1;
        exp_stall = 1'b0;
        nxt = reg_m;
        if (!r) begin
            // Producers still outstanding after this cycle's write-back lands.
            for (int i = 0; i < NR; i++) begin
                pend[i] = busy_m[i] && !(we && (int'(wa) == i));
            end
            pend[0] = 1'b0;
            exp_stall = (rq || iv) && (pend[a1] || pend[a2] || (iv && pend[ird]));
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            // Architectural state after this cycle's write; the read sees it.
            if (we && (wa != 5'd0)) begin
                nxt[wa] = wd;
            end
            if (rq && !exp_stall) begin
                p.r1 = nxt[a1];
                p.r2 = nxt[a2];
                exp_q.push_back(p);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                reg_m[i]  = '0;
                busy_m[i] = 1'b0;
            end
            exp_q.delete();
            hold1  = '0;
            hold2  = '0;
            mon_en = 1'b1;
        end else begin
            reg_m = nxt;
            if (we && (wa != 5'd0)) busy_m[wa] = 1'b0;
            if (iv && !exp_stall && (ird != 5'd0)) busy_m[ird] = 1'b1;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    // Monitor: compares read-port outputs against the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_valid", {31'd0, rd_valid}, {31'd0, (exp_q.size() > 0)});
            if (exp_q.size() > 0) begin
                pair_t p;
                p = exp_q.pop_front();
                if (rd_valid === 1'b1) begin
                    check("rs1_data", rs1_data, p.r1);
                    check("rs2_data", rs2_data, p.r2);
                    hold1 = p.r1;
                    hold2 = p.r2;
                end
            end else if (rd_valid !== 1'b1) begin
                check("rs1_hold", rs1_data, hold1);
                check("rs2_hold", rs2_data, hold2);
            end
        end
    end

    initial begin
        logic          r, we, rq, iv;
        logic [AW-1:0] wa, a1, a2, ird;
        logic [DW-1:0] wd;
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        hold1    = '0;
        hold2    = '0;
        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rd_req = 1'b0; rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0;

        // Reset overrides concurrent write, read and issue.
        step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3);
        // Reset then read.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0);
        // Write then read.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0);
        // Same-cycle bypass.
        step(1'b0, 1'b1, 5'd7, 32'h0000_0011, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h0000_0022, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0);
        idle();
        // x0 rules.
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        // RAW stall and release.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'h0000_1234, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd9, 1'b0, 5'd0);
        // Set/clear collision, then reset while busy.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4);
        step(1'b0, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd4);
        idle();

        // Random traffic over a small index range to force frequent hazards.
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            rq  = 1'($urandom_range(0, 1));
            a1  = 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            iv  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            step(r, we, wa, wd, rq, a1, a2, iv, ird);
        end
        idle();
        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Architectural integer register file with an integrated scoreboard.
- Sits directly downstream of the write-back stage: it consumes the write-back address, data and enable. It also serves the decode stage with two registered read ports and a RAW/WAW hazard stall.
- Write-to-read bypass within the same cycle.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the read/write data.
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_en  in  1  write enable from write-back.
- wb_addr  in  REG_ADDR_WIDTH  write-back destination register.
- wb_data  in  DATA_WIDTH  write-back result.
- rd_req  in  1  decode read request for this cycle.
- rs1_addr  in  REG_ADDR_WIDTH  source register 1 index.
- rs2_addr  in  REG_ADDR_WIDTH  source register 2 index.
- rs1_data  out  DATA_WIDTH  registered read data, port 1.
- rs2_data  out  DATA_WIDTH  registered read data, port 2.
- rd_valid  out  1  rs1_data/rs2_data valid (one cycle after an accepted rd_req).
- issue_valid  in  1  decode issues a uop that writes issue_rd.
- issue_rd  in  REG_ADDR_WIDTH  destination of the issuing uop.
- stall  out  1  combinational hazard indication to decode.

Behaviour:
- Reset (synchronous, active-high):
  - All NUM_REGS registers are cleared to 0.
  - All busy bits are cleared.
  - rs1_data = 0, rs2_data = 0, rd_valid = 0.
  - stall is 0 in the cycle after reset deasserts.
  - Reset overrides any concurrent wb_en, rd_req or issue_valid in the same cycle.
- Write:
  - When wb_en = 1 and wb_addr != 0, reg[wb_addr] <= wb_data at the clock edge.
  - Writes to x0 are discarded.
- Read:
  - Accepted when rd_req = 1 and stall = 0.
  - rs1_data/rs2_data and rd_valid = 1 update at the next edge (latency 1).
  - When no read is accepted, rd_valid <= 0 and the data outputs hold their last value.
  - Index 0 always returns 0.
  - Bypass: if wb_en = 1 and wb_addr == rsN_addr != 0 in the same cycle, rsN_data <= wb_data, not the old array value.
- Scoreboard:
  - One busy bit per register; busy[0] is constantly 0.
  - Set: an issue is accepted when issue_valid = 1, stall = 0 and issue_rd != 0. It sets busy[issue_rd].
  - Clear: wb_en = 1 with wb_addr != 0 clears busy[wb_addr].
  - Set and clear of the same index in one cycle: set wins, so busy stays 1 (new producer).
- Hazard (combinational):
  - hit(r) = busy[r] and not (wb_en and wb_addr == r), with r != 0.
  - stall = (rd_req or issue_valid) and (hit(rs1_addr) or hit(rs2_addr) or (issue_valid and hit(issue_rd))).
  - A register being written back this cycle never stalls; bypass supplies its data.
  - While stall = 1, no read is accepted and no busy bit is set.
  - stall does not block write-back; wb_en is always accepted.
- Decode asserts rd_req and issue_valid together for an instruction; the two are evaluated on the same stall.

Test Plan:
- Reset then read: reset 1 cycle, rd_req with rs1 = 3, rs2 = 0 -> next cycle rd_valid = 1, rs1_data = 0, rs2_data = 0.
- Write then read: wb_en, wb_addr = 5, wb_data = 0xDEADBEEF; next cycle rd_req rs1 = 5 -> rs1_data = 0xDEADBEEF one cycle later.
- Same-cycle bypass: reg[7] = 0x11; wb_en, wb_addr = 7, wb_data = 0x22 concurrent with rd_req rs2 = 7 -> rs2_data = 0x22 next cycle, stall = 0.
- x0 rule: wb_en, wb_addr = 0, data = 0xFFFFFFFF; then read x0 -> 0. issue_rd = 0 never sets busy; a later rs1 = 0 read never stalls.
- RAW stall/release: issue_valid, issue_rd = 9 accepted; next cycle rd_req rs1 = 9 -> stall = 1, rd_valid stays 0. wb_en, wb_addr = 9, data = 0x1234 arrives -> stall = 0 that cycle, rs1_data = 0x1234 next cycle, busy[9] = 0.
- Set/clear collision and mid-operation reset:
  - issue_rd = 4 accepted in the same cycle as wb_addr = 4 -> busy[4] stays 1, later rs1 = 4 stalls.
  - Assert reset while busy[4] = 1 -> stall = 0 after reset, reg[4] reads 0.
